// File: rtl/mic1_mem_serdes.sv
// mic1_mem_serdes
//   Serialises one MIC-1 memory access (word address plus optional write
//   word) into little-endian BUS_W-wide beats on the TinyTapeout pin bus,
//   and collects read data the same way. Every beat is a strobe/ack
//   handshake. A beat that waits WAIT_MAX strobe cycles without an ack
//   aborts the transfer and returns it with the error flag set.
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   ena_i              clock enable; low freezes all state and outputs
//   req_valid_i        core request; accepted only while req_ready_o is high
//   req_ready_o        high only while idle
//   req_we_i           1 = write, 0 = read
//   req_addr_i         word address
//   req_wdata_i        write data
//   rsp_valid_o        one-cycle completion pulse
//   rsp_rdata_o        read data; kept until the next read completes, 0 after
//                      a write or an aborted transfer
//   rsp_err_o          timeout flag, qualified by rsp_valid_o
//   bus_out_o          outgoing beat (address or write data), 0 otherwise
//   bus_oe_o           high during address and write-data beats
//   bus_in_i           incoming read beat
//   bus_phase_o        00 idle, 01 address, 10 write data, 11 read data
//   bus_strobe_o       beat presented
//   bus_ack_i          beat accepted or supplied by the external side
//
// State table
//   state   | meaning
//   S_IDLE  | waiting for a core request, req_ready_o high
//   S_ADDR  | sending address beats, LSB slice first
//   S_WDATA | sending write-data beats, LSB slice first
//   S_RDATA | collecting read-data beats, LSB slice first
//   S_RESP  | one-cycle completion pulse, then back to idle
//
// All outputs come straight from flops; nothing from bus_ack_i or
// req_valid_i reaches an output without passing a register.

module mic1_mem_serdes #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int BUS_W    = 8,
   parameter int WAIT_MAX = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic              rsp_err_o,
   output logic [BUS_W-1:0]  bus_out_o,
   output logic              bus_oe_o,
   input  logic [BUS_W-1:0]  bus_in_i,
   output logic [1:0]        bus_phase_o,
   output logic              bus_strobe_o,
   input  logic              bus_ack_i
);

   localparam int NA   = ADDR_W / BUS_W;
   localparam int ND   = DATA_W / BUS_W;
   localparam int NMAX = (NA > ND) ? NA : ND;
   localparam int IW   = (NMAX > 1) ? $clog2(NMAX) : 1;
   localparam int WW   = $clog2(WAIT_MAX + 1);
   localparam int TX_W = ADDR_W + DATA_W;

   localparam logic [IW-1:0] IDX_A_LAST = IW'(NA - 1);
   localparam logic [IW-1:0] IDX_D_LAST = IW'(ND - 1);
   // Compare against WAIT_MAX-1: the no-ack cycle seen while the counter
   // sits here is the one that brings it to WAIT_MAX.
   localparam logic [WW-1:0] WAIT_LAST  = WW'(WAIT_MAX - 1);

   localparam logic [1:0] PH_IDLE  = 2'b00;
   localparam logic [1:0] PH_ADDR  = 2'b01;
   localparam logic [1:0] PH_WDATA = 2'b10;
   localparam logic [1:0] PH_RDATA = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_WDATA,
      S_RDATA,
      S_RESP
   } state_t;

   state_t            state_q;
   logic [TX_W-1:0]   tx_q;
   logic              we_q;
   logic [IW-1:0]     idx_q;
   logic [WW-1:0]     wait_q;
   logic [DATA_W-1:0] rbuf_q;
   logic              req_ready_q;
   logic              rsp_valid_q;
   logic              rsp_err_q;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic [BUS_W-1:0]  bus_out_q;
   logic              bus_oe_q;
   logic              bus_strobe_q;
   logic [1:0]        bus_phase_q;

   // Address and write data travel as one shift register, address in the
   // low half, so the next outgoing beat is always the low slice.
   logic [TX_W-1:0]   req_tx;
   logic [TX_W-1:0]   tx_d;
   logic [DATA_W-1:0] rbuf_d;
   logic              beat_last;
   logic              wait_hit;

   assign req_tx    = {req_wdata_i, req_addr_i};
   assign tx_d      = tx_q >> BUS_W;
   // Read beats enter at the top and shift down, so the first beat ends
   // up in the LSB slice once all ND beats are in.
   assign rbuf_d    = (rbuf_q >> BUS_W) | (DATA_W'(bus_in_i) << (DATA_W - BUS_W));
   assign beat_last = (state_q == S_ADDR) ? (idx_q == IDX_A_LAST) : (idx_q == IDX_D_LAST);
   assign wait_hit  = (wait_q == WAIT_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         tx_q         <= '0;
         we_q         <= 1'b0;
         idx_q        <= '0;
         wait_q       <= '0;
         rbuf_q       <= '0;
         req_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_rdata_q  <= '0;
         bus_out_q    <= '0;
         bus_oe_q     <= 1'b0;
         bus_strobe_q <= 1'b0;
         bus_phase_q  <= PH_IDLE;
      end else if (ena_i) begin
         case (state_q)
            S_IDLE: begin
               if (req_valid_i) begin
                  state_q      <= S_ADDR;
                  tx_q         <= req_tx >> BUS_W;
                  we_q         <= req_we_i;
                  idx_q        <= '0;
                  wait_q       <= '0;
                  req_ready_q  <= 1'b0;
                  bus_out_q    <= req_tx[BUS_W-1:0];
                  bus_oe_q     <= 1'b1;
                  bus_strobe_q <= 1'b1;
                  bus_phase_q  <= PH_ADDR;
               end
            end

            S_ADDR, S_WDATA, S_RDATA: begin
               if (bus_ack_i) begin
                  wait_q <= '0;
                  if (state_q == S_RDATA) begin
                     rbuf_q <= rbuf_d;
                  end
                  if (!beat_last) begin
                     idx_q <= idx_q + 1'b1;
                     if (state_q != S_RDATA) begin
                        bus_out_q <= tx_q[BUS_W-1:0];
                        tx_q      <= tx_d;
                     end
                  end else if (state_q == S_ADDR) begin
                     idx_q <= '0;
                     if (we_q) begin
                        state_q     <= S_WDATA;
                        bus_phase_q <= PH_WDATA;
                        bus_out_q   <= tx_q[BUS_W-1:0];
                        tx_q        <= tx_d;
                     end else begin
                        state_q     <= S_RDATA;
                        bus_phase_q <= PH_RDATA;
                        bus_oe_q    <= 1'b0;
                        bus_out_q   <= '0;
                     end
                  end else begin
                     state_q      <= S_RESP;
                     rsp_valid_q  <= 1'b1;
                     rsp_err_q    <= 1'b0;
                     rsp_rdata_q  <= (state_q == S_RDATA) ? rbuf_d : '0;
                     bus_out_q    <= '0;
                     bus_oe_q     <= 1'b0;
                     bus_strobe_q <= 1'b0;
                     bus_phase_q  <= PH_IDLE;
                  end
               end else if (wait_hit) begin
                  state_q      <= S_RESP;
                  rsp_valid_q  <= 1'b1;
                  rsp_err_q    <= 1'b1;
                  rsp_rdata_q  <= '0;
                  wait_q       <= '0;
                  bus_out_q    <= '0;
                  bus_oe_q     <= 1'b0;
                  bus_strobe_q <= 1'b0;
                  bus_phase_q  <= PH_IDLE;
               end else begin
                  wait_q <= wait_q + 1'b1;
               end
            end

            S_RESP: begin
               state_q     <= S_IDLE;
               rsp_valid_q <= 1'b0;
               req_ready_q <= 1'b1;
            end

            default: begin
               state_q      <= S_IDLE;
               req_ready_q  <= 1'b1;
               rsp_valid_q  <= 1'b0;
               bus_out_q    <= '0;
               bus_oe_q     <= 1'b0;
               bus_strobe_q <= 1'b0;
               bus_phase_q  <= PH_IDLE;
            end
         endcase
      end
   end

   assign req_ready_o  = req_ready_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_err_o    = rsp_err_q;
   assign rsp_rdata_o  = rsp_rdata_q;
   assign bus_out_o    = bus_out_q;
   assign bus_oe_o     = bus_oe_q;
   assign bus_strobe_o = bus_strobe_q;
   assign bus_phase_o  = bus_phase_q;

endmodule
